core_feed_ctl: RTL
==================

# core_feed_ctl

Issue-side controller for the convolution/FC MAC core controller. It accepts CNN window+filter beats and FC data+weight beats from the upstream buffers over valid/ready handshakes. It then drives the core's `cnn_ready`/`cnn_data`/`filter_data` and `fc_ready`/`fc_data`/`weight_data` inputs with registered outputs. Each FC group of exactly three beats is issued atomically on three consecutive cycles, and CNN and FC are never asserted together. The block also tracks in-flight beats so the top level can tell when the core has drained.

## Interface
- `DATA_W`, 72, beat width (nine 8-bit lanes)
- `PIPE_DEPTH`, 5, core issue-to-result cycles tracked (4 to `cnn_out`, +1 for the registered `out_now`)

- `clk` in 1, single clock
- `rst_n` in 1, synchronous active-low reset
- `flush` in 1, drop queued, un-issued beats
- `cnn_req_valid` in 1 / `cnn_req_ready` out 1, CNN beat handshake
- `cnn_req_data` in DATA_W, window pixels
- `cnn_req_filter` in DATA_W, kernel weights
- `fc_req_valid` in 1 / `fc_req_ready` out 1, FC beat handshake
- `fc_req_data` in DATA_W, FC activations
- `fc_req_weight` in DATA_W, FC weights
- `cnn_ready` out 1, CNN beat valid to core
- `cnn_data` out DATA_W, CNN data to core
- `filter_data` out DATA_W, filter to core
- `fc_ready` out 1, FC beat valid to core
- `fc_data` out DATA_W, FC data to core
- `weight_data` out DATA_W, FC weight to core
- `idle` out 1, queues empty, no issue in progress, pipeline drained
- `perf_cnn_beats` out 32, `perf_fc_groups` out 32, `perf_cnn_stall` out 32, performance counters

## Operation
- CNN path: 2-entry FIFO. `cnn_req_ready = (count < 2)`, decoded from registered count only. Push and pop in the same cycle are legal.
- FC path: 3-entry staging buffer with `fc_cnt` 0..3. Beats are written in arrival order. `fc_req_ready = (state == ISSUE) && (fc_cnt != 3)`.
- FSM states ISSUE, FC1, FC2. Each cycle the outputs are registered as follows.
  - ISSUE, `fc_cnt == 3`: issue entry0 with `fc_ready=1`, go to FC1. FC has strict priority.
  - ISSUE, otherwise, CNN FIFO non-empty: pop and issue with `cnn_ready=1`.
  - ISSUE, otherwise: both valids 0.
  - FC1: issue entry1, go to FC2.
  - FC2: issue entry2, set `fc_cnt ← 0`, go to ISSUE.
- Data outputs hold their last issued value when the corresponding valid is 0.
- `cnn_ready & fc_ready` is never 1.
- `flush` in ISSUE clears both queues. A push on the same cycle is also dropped. During FC1/FC2 the group completes, and only the CNN FIFO is cleared immediately. FC staging is cleared at group end, after which `fc_cnt` is 0.
- In-flight tracker: a PIPE_DEPTH-bit shift register, shifted in with `cnn_ready | fc_ready`.
- `idle` = both queues empty, state ISSUE, both valids 0, tracker all-zero.

## Timing
- Reset: all outputs 0, `cnn_req_ready=1`, `fc_req_ready=1`, `idle=1`, state ISSUE, counters 0.
- Reset asserted mid-group aborts the group. The core must be reset together with this block.
- Latency: a CNN beat accepted at edge E is visible on `cnn_ready` after edge E+1 at the earliest.
- A third FC beat accepted at edge E gives `fc_ready` high for the three cycles following edge E+1.
- When FC preempts, CNN waits. A CNN beat waits at most 3 cycles per queued FC group.
- `idle` rises PIPE_DEPTH cycles after the last issue cycle.

## Configuration
- `CORE_FEED_PERF_EN` defined: three 32-bit wrapping counters.
  - `perf_cnn_beats` increments per CNN issue.
  - `perf_fc_groups` increments on each FC2 issue.
  - `perf_cnn_stall` increments on cycles with the CNN FIFO non-empty while `fc_ready=1`.
  - All clear on reset, not on `flush`.
- Undefined: ports remain, tied to 0, no counter flops.

## Structure
- Package `core_feed_pkg`: state encoding (ISSUE, FC1, FC2), `FC_GROUP_LEN=3`, `CNN_FIFO_DEPTH=2`, default `DATA_W`.
- Sub-module `core_feed_fifo2`: 2-entry synchronous FIFO with push/pop/flush, used for the CNN path.

## Test plan
- Reset, then 4 back-to-back CNN beats A..D with FC idle → `cnn_ready` high for 4 consecutive cycles starting 2 cycles after the first acceptance, data A..D in order. `idle` returns 5 cycles after D.
- 3 FC beats F0..F2, then CNN beats queued → `fc_ready` high for exactly 3 cycles carrying F0,F1,F2, CNN beats follow. `cnn_ready` is never coincident with `fc_ready`.
- CNN FIFO full (2 beats) while an FC group issues → `cnn_req_ready=0`, both CNN beats issue right after FC2, `perf_cnn_stall=3` with the macro defined.
- `flush` during FC1 with 1 CNN beat queued → F1 and F2 still issue, the CNN beat is never issued, `fc_cnt=0` afterwards.
- Only 2 FC beats supplied → `fc_ready` stays 0 indefinitely, `idle=0`. A third beat then triggers the full group.
- `rst_n` low during FC2 → next cycle all outputs 0, `idle=1`, counters 0.

Source files
------------

// File: rtl/core_feed_pkg.sv
// core_feed_pkg: shared state encoding and sizing constants for the core feed controller.
package core_feed_pkg;

   localparam int unsigned FC_GROUP_LEN   = 3;
   localparam int unsigned CNN_FIFO_DEPTH = 2;
   localparam int unsigned DEFAULT_DATA_W = 72;

   typedef enum logic [1:0] {
      StIssue = 2'd0,
      StFc1   = 2'd1,
      StFc2   = 2'd2
   } feed_state_e;

   // Staging slot that is issued while the FSM sits in a given state.
   function automatic logic [1:0] fc_slot(input feed_state_e st);
      case (st)
         StFc1:   return 2'd1;
         StFc2:   return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/core_feed_fifo2.sv
// core_feed_fifo2: 2-entry synchronous FIFO with push, pop and flush.
// A push on a flush cycle is dropped; the flush empties the FIFO.
module core_feed_fifo2 import core_feed_pkg::*; #(
   parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flush,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_empty,
   output logic              o_full
);

   logic [DATA_W-1:0] r_mem [CNN_FIFO_DEPTH];
   logic              r_rd_ptr;
   logic              r_wr_ptr;
   logic [1:0]        r_count;
   logic              w_push;
   logic              w_pop;

   assign o_full  = (r_count == 2'(CNN_FIFO_DEPTH));
   assign o_empty = (r_count == 2'd0);
   assign w_push  = i_push & ~i_flush & ~o_full;
   assign w_pop   = i_pop & ~i_flush & ~o_empty;
   assign o_data  = r_mem[r_rd_ptr];

   // Pointer and occupancy update; simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; the occupancy count guards reads.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/core_feed_ctl.sv
// core_feed_ctl: issue-side controller feeding CNN beats and atomic 3-beat FC groups to the
// MAC core with registered outputs, plus an in-flight tracker for drain detection.
// Optional performance counters are built when CORE_FEED_PERF_EN is defined.
module core_feed_ctl import core_feed_pkg::*; #(
   parameter int unsigned DATA_W     = DEFAULT_DATA_W,
   parameter int unsigned PIPE_DEPTH = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flush,
   input  logic              i_cnn_req_valid,
   output logic              o_cnn_req_ready,
   input  logic [DATA_W-1:0] i_cnn_req_data,
   input  logic [DATA_W-1:0] i_cnn_req_filter,
   input  logic              i_fc_req_valid,
   output logic              o_fc_req_ready,
   input  logic [DATA_W-1:0] i_fc_req_data,
   input  logic [DATA_W-1:0] i_fc_req_weight,
   output logic              o_cnn_ready,
   output logic [DATA_W-1:0] o_cnn_data,
   output logic [DATA_W-1:0] o_filter_data,
   output logic              o_fc_ready,
   output logic [DATA_W-1:0] o_fc_data,
   output logic [DATA_W-1:0] o_weight_data,
   output logic              o_idle,
   output logic [31:0]       o_perf_cnn_beats,
   output logic [31:0]       o_perf_fc_groups,
   output logic [31:0]       o_perf_cnn_stall
);

   feed_state_e         r_state;
   feed_state_e         w_state_d;
   logic [1:0]          r_fc_cnt;
   logic [DATA_W-1:0]   r_fc_buf_data   [FC_GROUP_LEN];
   logic [DATA_W-1:0]   r_fc_buf_weight [FC_GROUP_LEN];
   logic                r_cnn_ready;
   logic                r_fc_ready;
   logic [DATA_W-1:0]   r_cnn_data;
   logic [DATA_W-1:0]   r_filter_data;
   logic [DATA_W-1:0]   r_fc_data;
   logic [DATA_W-1:0]   r_weight_data;
   logic [PIPE_DEPTH-1:0] r_inflight;

   logic                w_issue_cnn;
   logic                w_issue_fc;
   logic                w_fc_clr;
   logic                w_fc_push;
   logic                w_cnn_push;
   logic                w_cnn_empty;
   logic                w_cnn_full;
   logic [2*DATA_W-1:0] w_cnn_head;
   logic [1:0]          w_slot;

   assign o_cnn_req_ready = ~w_cnn_full;
   assign o_fc_req_ready  = (r_state == StIssue) && (r_fc_cnt != 2'(FC_GROUP_LEN));
   assign w_cnn_push      = i_cnn_req_valid & o_cnn_req_ready;
   assign w_fc_push       = i_fc_req_valid & o_fc_req_ready & ~i_flush;
   assign w_slot          = fc_slot(r_state);

   core_feed_fifo2 #(
      .DATA_W (2 * DATA_W)
   ) u_cnn_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_flush),
      .i_push  (w_cnn_push),
      .i_data  ({i_cnn_req_filter, i_cnn_req_data}),
      .i_pop   (w_issue_cnn),
      .o_data  (w_cnn_head),
      .o_empty (w_cnn_empty),
      .o_full  (w_cnn_full)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= StIssue;
      else          r_state <= w_state_d;
   end

   // Issue decision: flush wins in ISSUE, then a full FC group, then a queued CNN beat.
   always_comb begin
      w_state_d   = r_state;
      w_issue_cnn = 1'b0;
      w_issue_fc  = 1'b0;
      w_fc_clr    = 1'b0;
      unique case (r_state)
         StIssue: begin
            if (i_flush) begin
               w_fc_clr = 1'b1;
            end else if (r_fc_cnt == 2'(FC_GROUP_LEN)) begin
               w_issue_fc = 1'b1;
               w_state_d  = StFc1;
            end else if (!w_cnn_empty) begin
               w_issue_cnn = 1'b1;
            end
         end
         StFc1: begin
            w_issue_fc = 1'b1;
            w_state_d  = StFc2;
         end
         StFc2: begin
            w_issue_fc = 1'b1;
            w_fc_clr   = 1'b1;
            w_state_d  = StIssue;
         end
         default: w_state_d = StIssue;
      endcase
   end

   // FC staging occupancy; a flush mid-group takes effect when FC2 clears it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)       r_fc_cnt <= 2'd0;
      else if (w_fc_clr)  r_fc_cnt <= 2'd0;
      else if (w_fc_push) r_fc_cnt <= r_fc_cnt + 2'd1;
   end

   // FC staging storage, written in arrival order.
   always_ff @(posedge i_clk) begin
      if (w_fc_push) begin
         r_fc_buf_data[r_fc_cnt]   <= i_fc_req_data;
         r_fc_buf_weight[r_fc_cnt] <= i_fc_req_weight;
      end
   end

   // Registered core-side outputs; data holds its last issued value.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnn_ready   <= 1'b0;
         r_fc_ready    <= 1'b0;
         r_cnn_data    <= '0;
         r_filter_data <= '0;
         r_fc_data     <= '0;
         r_weight_data <= '0;
      end else begin
         r_cnn_ready <= w_issue_cnn;
         r_fc_ready  <= w_issue_fc;
         if (w_issue_cnn) {r_filter_data, r_cnn_data} <= w_cnn_head;
         if (w_issue_fc) begin
            r_fc_data     <= r_fc_buf_data[w_slot];
            r_weight_data <= r_fc_buf_weight[w_slot];
         end
      end
   end

   // In-flight tracker: one bit per cycle of core pipeline latency.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_inflight <= '0;
      else          r_inflight <= {r_inflight[PIPE_DEPTH-2:0], r_cnn_ready | r_fc_ready};
   end

   assign o_cnn_ready   = r_cnn_ready;
   assign o_fc_ready    = r_fc_ready;
   assign o_cnn_data    = r_cnn_data;
   assign o_filter_data = r_filter_data;
   assign o_fc_data     = r_fc_data;
   assign o_weight_data = r_weight_data;
   assign o_idle        = w_cnn_empty && (r_fc_cnt == 2'd0) && (r_state == StIssue) &&
                          !r_cnn_ready && !r_fc_ready && (r_inflight == '0);

`ifdef CORE_FEED_PERF_EN
   logic [31:0] r_perf_cnn_beats;
   logic [31:0] r_perf_fc_groups;
   logic [31:0] r_perf_cnn_stall;

   // Wrapping counters; flush leaves them untouched.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_perf_cnn_beats <= '0;
         r_perf_fc_groups <= '0;
         r_perf_cnn_stall <= '0;
      end else begin
         if (w_issue_cnn) r_perf_cnn_beats <= r_perf_cnn_beats + 32'd1;
         if (w_issue_fc && (r_state == StFc2)) r_perf_fc_groups <= r_perf_fc_groups + 32'd1;
         if (r_fc_ready && !w_cnn_empty) r_perf_cnn_stall <= r_perf_cnn_stall + 32'd1;
      end
   end

   assign o_perf_cnn_beats = r_perf_cnn_beats;
   assign o_perf_fc_groups = r_perf_fc_groups;
   assign o_perf_cnn_stall = r_perf_cnn_stall;
`else
   assign o_perf_cnn_beats = '0;
   assign o_perf_fc_groups = '0;
   assign o_perf_cnn_stall = '0;
`endif

endmodule
